result_writeback: RTL and testbench
===================================

Name: result_writeback

Overview:
- Downstream drain stage of the vector multiplier.
- After a compute pass, it reads 24-bit partial-sum words from the results SRAM and requantizes each lane to int8 (arithmetic shift, rounding, saturation).
- It packs the 32 int8 lanes into one unified-buffer word and writes that word back to the unified buffer, so the next layer can use it as input.
- The controller sequences it with a start/busy/done handshake.

Parameters:
- ADDRESSSIZE, 10, address width of both the results SRAM and the unified buffer.
- MATRIX_SIZE, 32, lanes per word.
- PARTIAL_SUM_BW, 24, signed width of each input lane.
- DATA_BW, 8, signed width of each output lane.
- SHIFT_BW, 5, width of the shift-amount input.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rstn  input  1  reset. Synchronous, active-high (1 = reset). The name is kept for codebase consistency.
- start  input  1  begin a transfer; sampled only in IDLE.
- num_words  input  ADDRESSSIZE  number of words to move.
- src_base  input  ADDRESSSIZE  first results-SRAM address.
- dst_base  input  ADDRESSSIZE  first unified-buffer address.
- shift  input  SHIFT_BW  arithmetic right-shift amount, 0..23.
- res_rd_en  output  1  results-SRAM read strobe.
- res_rd_addr  output  ADDRESSSIZE  results-SRAM read address.
- res_rd_data  input  PARTIAL_SUM_BW*MATRIX_SIZE  read data, valid 1 cycle after res_rd_en.
- ub_wr_en  output  1  unified-buffer write request.
- ub_wr_addr  output  ADDRESSSIZE  unified-buffer write address.
- ub_wr_data  output  DATA_BW*MATRIX_SIZE  packed int8 word.
- ub_wr_ready  input  1  unified buffer accepts the write this cycle.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state goes to IDLE; index and all registers clear; every output is 0.
- Reset asserted mid-transfer aborts the transfer immediately, with no done pulse. Rows already written stay written.
- Outputs are decoded from the registered state. No combinational path from any input to any output.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE, start=1: latch num_words, src_base, dst_base, shift; clear idx.
  - num_words=0: go to DONE.
  - otherwise: go to READ.
- start=1 in any state other than IDLE is ignored.
- READ: res_rd_en=1, res_rd_addr = src_base+idx (mod 2^ADDRESSSIZE). Next state WAIT.
- WAIT: capture res_rd_data, requantize, store the result in the output register. Next state WRITE.
- WRITE: ub_wr_en=1, ub_wr_addr = dst_base+idx (mod 2^ADDRESSSIZE), ub_wr_data = output register.
  - All three stay stable while ub_wr_ready=0. No extra reads are issued.
  - When ub_wr_ready=1: if idx = num_words-1, go to DONE; otherwise idx++ and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ, WAIT and WRITE; 0 otherwise.
- Throughput with ready held high: one word per 3 cycles. The last write is at start+3*num_words; done is at start+3*num_words+1.
- Lane mapping: input lane i is res_rd_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]; output lane i is ub_wr_data[i*DATA_BW +: DATA_BW].
- Requantization, per lane, signed:
  - r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at PARTIAL_SUM_BW+1 bits so the rounding add cannot overflow.
  - Saturate r to [-128, 127].
- shift > 23 is clamped to 23.

Optional Feature:
- Macro: RESULT_WB_RELU_EN.
- Defined: adds input port relu_en (1 bit), latched on start. When the latched relu_en=1, any lane whose rounded r is negative outputs 0 before saturation.
- Undefined: no relu_en port; pure signed requantization.

Test Plan:
- Single word, all lanes 0x000100, shift=1, ready=1 -> all lanes 0x7F (128 saturates); done 4 cycles after start; exactly one read and one write.
- Lanes -300, 5, -5, 0x7FFFFF with shift 0, 1, 1, 23 respectively -> 0x80, 0x03, 0xFE, 0x01; mixed lane positions show no cross-lane leakage.
- num_words=4, src_base=0x3FE, dst_base=0x010, ready=1:
  - reads at 0x3FE, 0x3FF, 0x000, 0x001;
  - writes at 0x010..0x013;
  - done exactly at start+13.
- Word 2 sees ub_wr_ready=0 for 5 cycles -> ub_wr_en, address and data stay constant, no res_rd_en during the stall; done slips by 5 cycles; start pulses during busy are ignored.
- num_words=0 -> done at start+1; res_rd_en and ub_wr_en never assert.
- rstn asserted in WAIT of word 1 -> next cycle every output is 0 and state is IDLE, with no done pulse; a new start runs normally.
- With RESULT_WB_RELU_EN defined and relu_en=1 -> lane -5, shift 1 outputs 0x00.

Source files
------------

// File: rtl/result_writeback.sv
// Drains 24-bit partial sums from the results SRAM, requantizes each lane to int8 and writes packed words to the unified buffer.
// Optional RESULT_WB_RELU_EN adds a relu_en input latched on start that zeroes negative lanes.
module result_writeback #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8,
  parameter int SHIFT_BW       = 5
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [ADDRESSSIZE-1:0]             num_words,
  input  logic [ADDRESSSIZE-1:0]             src_base,
  input  logic [ADDRESSSIZE-1:0]             dst_base,
  input  logic [SHIFT_BW-1:0]                shift,
`ifdef RESULT_WB_RELU_EN
  input  logic                               relu_en,
`endif
  output logic                               res_rd_en,
  output logic [ADDRESSSIZE-1:0]             res_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_rd_data,
  output logic                               ub_wr_en,
  output logic [ADDRESSSIZE-1:0]             ub_wr_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]     ub_wr_data,
  input  logic                               ub_wr_ready,
  output logic                               busy,
  output logic                               done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [SHIFT_BW-1:0] SHIFT_MAX = SHIFT_BW'(PARTIAL_SUM_BW - 1);
  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MAX = (PARTIAL_SUM_BW+1)'((1 << (DATA_BW - 1)) - 1);
  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MIN = ~SAT_MAX;

  state_t state, next_state;
  logic [ADDRESSSIZE-1:0] idx, num_q, src_q, dst_q;
  logic [SHIFT_BW-1:0] shift_q;
  logic [DATA_BW*MATRIX_SIZE-1:0] out_q, quant;
  logic relu_q;
  logic last;

  assign last = (idx == num_q - ADDRESSSIZE'(1));

  // Extra headroom bit keeps the rounding add from wrapping at full-scale input.
  function automatic logic [DATA_BW-1:0] requant(input logic [PARTIAL_SUM_BW-1:0] x,
                                                 input logic [SHIFT_BW-1:0] sh,
                                                 input logic relu);
    logic signed [PARTIAL_SUM_BW:0] ext, rnd, r;
    logic [DATA_BW-1:0] res;
    ext = signed'({x[PARTIAL_SUM_BW-1], x});
    rnd = '0;
    if (sh != '0) rnd[sh - SHIFT_BW'(1)] = 1'b1;
    r = (ext + rnd) >>> sh;
    if (relu && r[PARTIAL_SUM_BW]) r = '0;
    if (r > SAT_MAX)      res = SAT_MAX[DATA_BW-1:0];
    else if (r < SAT_MIN) res = SAT_MIN[DATA_BW-1:0];
    else                  res = r[DATA_BW-1:0];
    return res;
  endfunction

  always_comb begin
    quant = '0;
    for (int i = 0; i < MATRIX_SIZE; i++)
      quant[i*DATA_BW +: DATA_BW] = requant(res_rd_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], shift_q, relu_q);
  end

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_words == '0) ? DONE : READ;
      READ:    next_state = WAIT;
      WAIT:    next_state = WRITE;
      WRITE:   if (ub_wr_ready) next_state = last ? DONE : READ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      idx     <= '0;
      num_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
    end else begin
      if (state == IDLE && start) begin
        idx     <= '0;
        num_q   <= num_words;
        src_q   <= src_base;
        dst_q   <= dst_base;
        shift_q <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
      end
      if (state == WAIT) out_q <= quant;
      if (state == WRITE && ub_wr_ready && !last) idx <= idx + ADDRESSSIZE'(1);
    end
  end

`ifdef RESULT_WB_RELU_EN
  always_ff @(posedge clk) begin
    if (rstn)                       relu_q <= 1'b0;
    else if (state == IDLE && start) relu_q <= relu_en;
  end
`else
  assign relu_q = 1'b0;
`endif

  always_comb begin
    res_rd_en   = 1'b0;
    res_rd_addr = '0;
    ub_wr_en    = 1'b0;
    ub_wr_addr  = '0;
    ub_wr_data  = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      READ: begin
        res_rd_en   = 1'b1;
        res_rd_addr = src_q + idx;
        busy        = 1'b1;
      end
      WAIT: busy = 1'b1;
      WRITE: begin
        ub_wr_en   = 1'b1;
        ub_wr_addr = dst_q + idx;
        ub_wr_data = out_q;
        busy       = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: SRAM model, randomized stalls, arithmetic reference model.
module tb_result_writeback;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start, relu_en;
  logic [9:0] num_words, src_base, dst_base;
  logic [4:0] shift;
  logic res_rd_en, ub_wr_en, ub_wr_ready, busy, done;
  logic [9:0] res_rd_addr, ub_wr_addr;
  logic [767:0] res_rd_data;
  logic [255:0] ub_wr_data;

  result_writeback dut (
    .clk(clk), .rstn(rstn), .start(start), .num_words(num_words),
    .src_base(src_base), .dst_base(dst_base), .shift(shift),
`ifdef RESULT_WB_RELU_EN
    .relu_en(relu_en),
`endif
    .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .ub_wr_ready(ub_wr_ready), .busy(busy), .done(done)
  );

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt, wr_cnt, stall_cnt, done_cnt = 0, done_cyc;
  int rand_rdy = 0, stall_left = 0;
  logic [9:0] stall_addr = 10'h0;
  logic [9:0] exp_rd[$], exp_wa[$];
  logic [255:0] exp_wd[$];
  logic [255:0] last_wr, h_data, lane_chk;
  logic [9:0] h_addr;
  bit held = 0;
  logic [767:0] mem [1024];
  logic pend_en = 1'b0;
  logic [9:0] pend_addr;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] model(logic [767:0] w, int sh, bit relu);
    logic [255:0] o;
    int x, r, s;
    s = (sh > 23) ? 23 : sh;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      x = $signed(w[i*24 +: 24]);
      r = (x + ((s > 0) ? (1 << (s - 1)) : 0)) >>> s;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      o[i*8 +: 8] = r[7:0];
    end
    return o;
  endfunction

  always @(posedge clk) cyc++;

  // Synchronous-read SRAM model; junk appears whenever no read was issued.
  always @(negedge clk) begin
    pend_en = res_rd_en;
    pend_addr = res_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    if (pend_en) res_rd_data = mem[pend_addr];
    else for (int j = 0; j < 24; j++) res_rd_data[j*32 +: 32] = $urandom;
    if (ub_wr_en && ub_wr_addr == stall_addr && stall_left > 0) begin
      ub_wr_ready = 1'b0;
      stall_left--;
    end else begin
      ub_wr_ready = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      if (res_rd_en) begin
        rd_cnt++;
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", res_rd_addr, exp_rd.pop_front());
        chk("rd_during_wr", ub_wr_en, 0);
      end
      if (ub_wr_en) begin
        if (held) begin
          chk("stall_addr", ub_wr_addr, h_addr);
          chk("stall_data", ub_wr_data, h_data);
        end
        if (ub_wr_ready) begin
          wr_cnt++;
          last_wr = ub_wr_data;
          held = 0;
          if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_addr", ub_wr_addr, exp_wa.pop_front());
            chk("wr_data", ub_wr_data, exp_wd.pop_front());
          end
        end else begin
          stall_cnt++;
          held = 1;
          h_addr = ub_wr_addr;
          h_data = ub_wr_data;
        end
      end else held = 0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic run(int n, logic [9:0] src, logic [9:0] dst, int sh, bit relu, int junk);
    int k, d0;
    bit got;
`ifndef RESULT_WB_RELU_EN
    relu = 0;
`endif
    for (int w = 0; w < n; w++) begin
      exp_rd.push_back(src + 10'(w));
      exp_wa.push_back(dst + 10'(w));
      exp_wd.push_back(model(mem[src + 10'(w)], sh, relu));
    end
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; d0 = done_cnt;
    @(negedge clk);
    num_words = 10'(n); src_base = src; dst_base = dst; shift = 5'(sh); relu_en = relu; start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    num_words = 10'($urandom); src_base = 10'($urandom); dst_base = 10'($urandom);
    shift = 5'($urandom); relu_en = ~relu;
    for (int j = 0; j < junk; j++) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 3 * n + 300 && !got; c++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) got = 1;
    end
    chk("done_seen", got, 1);
    if (got) chk("done_cycle", done_cyc - k, 3 * n + 1 + stall_cnt);
    @(negedge clk); #1;
    chk("done_single", done_cnt - d0, 1);
    chk("idle_busy", busy, 0);
    chk("rd_count", rd_cnt, n);
    chk("wr_count", wr_cnt, n);
    chk("queues_empty", exp_rd.size() + exp_wa.size(), 0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k, d0;
    rstn = 1'b1; start = 1'b0; relu_en = 1'b0; ub_wr_ready = 1'b1;
    num_words = '0; src_base = '0; dst_base = '0; shift = '0;
    res_rd_data = '0;
    for (int i = 0; i < 1024; i++)
      for (int j = 0; j < 32; j++)
        mem[i][j*24 +: 24] = ($urandom_range(0, 1) != 0) ? 24'($urandom)
                                                         : 24'($urandom_range(0, 4000) - 2000);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {res_rd_en, res_rd_addr, ub_wr_en, ub_wr_addr, busy, done}, 0);
    chk("rst_data", ub_wr_data, 0);
    rstn = 1'b0;

    // Single word saturating to +127 in every lane.
    for (int j = 0; j < 32; j++) mem[5][j*24 +: 24] = 24'h000100;
    run(1, 10'd5, 10'd7, 1, 0, 0);
    chk("sat_all_lanes", last_wr, {32{8'h7F}});

    // Boundary lanes at scattered positions; rest of each word is random.
    mem[20][3*24 +: 24] = 24'hFFFED4;
    run(1, 10'd20, 10'd30, 0, 0, 0);
    lane_chk = last_wr; chk("lane_m300", lane_chk[3*8 +: 8], 8'h80);
    mem[21][17*24 +: 24] = 24'd5;
    run(1, 10'd21, 10'd31, 1, 0, 0);
    lane_chk = last_wr; chk("lane_p5", lane_chk[17*8 +: 8], 8'h03);
    mem[22][30*24 +: 24] = 24'hFFFFFB;
    run(1, 10'd22, 10'd32, 1, 0, 0);
    lane_chk = last_wr; chk("lane_m5", lane_chk[30*8 +: 8], 8'hFE);
    mem[23][0 +: 24] = 24'h7FFFFF;
    run(1, 10'd23, 10'd33, 23, 0, 0);
    lane_chk = last_wr; chk("lane_max", lane_chk[7:0], 8'h01);
    run(1, 10'd24, 10'd34, 31, 0, 0);

    // Address wrap on the read side.
    run(4, 10'h3FE, 10'h010, 4, 0, 0);

    // Stall on the second word with ignored start pulses during busy.
    stall_addr = 10'd201; stall_left = 5;
    run(4, 10'd100, 10'd200, 6, 0, 2);
    chk("stall_cycles", stall_cnt, 5);

    run(0, 10'd0, 10'd0, 0, 0, 0);

    // Reset while the first word is in WAIT.
    for (int w = 0; w < 2; w++) begin
      exp_rd.push_back(10'd300 + 10'(w));
      exp_wa.push_back(10'd400 + 10'(w));
      exp_wd.push_back(model(mem[10'd300 + 10'(w)], 3, 0));
    end
    d0 = done_cnt;
    @(negedge clk);
    num_words = 10'd2; src_base = 10'd300; dst_base = 10'd400; shift = 5'd3; relu_en = 1'b0; start = 1'b1;
    k = cyc;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #1;
    chk("abort_ctrl", {res_rd_en, res_rd_addr, ub_wr_en, ub_wr_addr, busy, done}, 0);
    chk("abort_data", ub_wr_data, 0);
    rstn = 1'b0;
    chk("abort_no_write", exp_wa.size(), 2);
    chk("abort_one_read", exp_rd.size(), 1);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    repeat (8) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    run(2, 10'd300, 10'd400, 3, 0, 0);

`ifdef RESULT_WB_RELU_EN
    mem[50][9*24 +: 24] = 24'hFFFFFB;
    run(1, 10'd50, 10'd60, 1, 1, 0);
    lane_chk = last_wr; chk("relu_lane", lane_chk[9*8 +: 8], 8'h00);
`endif

    rand_rdy = 1;
    for (int t = 0; t < 8; t++)
      run($urandom_range(1, 6), 10'($urandom), 10'($urandom), $urandom_range(0, 31),
          1'($urandom_range(0, 1)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
